// File: rtl/axi_burst_port_if.sv
// AXI4 read/write channel bundle between the burst port (master) and the interconnect (slave).
// Only the subset of AXI4 signals that the burst port actually drives or consumes is carried.
interface axi_burst_port_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) ();
  logic [ADDR_W-1:0] m_araddr;
  logic [7:0]        m_arlen;
  logic              m_arvalid;
  logic              m_arready;
  logic [DATA_W-1:0] m_rdata;
  logic [1:0]        m_rresp;
  logic              m_rlast;
  logic              m_rvalid;
  logic              m_rready;
  logic [ADDR_W-1:0] m_awaddr;
  logic [7:0]        m_awlen;
  logic              m_awvalid;
  logic              m_awready;
  logic [DATA_W-1:0] m_wdata;
  logic [3:0]        m_wstrb;
  logic              m_wlast;
  logic              m_wvalid;
  logic              m_wready;
  logic [1:0]        m_bresp;
  logic              m_bvalid;
  logic              m_bready;
  logic [2:0]        m_axsize;
  logic [1:0]        m_axburst;

  modport master (
    output m_araddr, m_arlen, m_arvalid, m_rready,
    output m_awaddr, m_awlen, m_awvalid, m_wdata, m_wstrb, m_wlast, m_wvalid, m_bready,
    output m_axsize, m_axburst,
    input  m_arready, m_rdata, m_rresp, m_rlast, m_rvalid,
    input  m_awready, m_wready, m_bresp, m_bvalid
  );

  modport slave (
    input  m_araddr, m_arlen, m_arvalid, m_rready,
    input  m_awaddr, m_awlen, m_awvalid, m_wdata, m_wstrb, m_wlast, m_wvalid, m_bready,
    input  m_axsize, m_axburst,
    output m_arready, m_rdata, m_rresp, m_rlast, m_rvalid,
    output m_awready, m_wready, m_bresp, m_bvalid
  );
endinterface

// File: rtl/axi_burst_port.sv
// Turns single rd_req/wr_req handshakes from the hline z-buffer FSM into fixed-length
// AXI4 INCR bursts; read beats go to the load FIFOs, write beats come from FWFT out-FIFOs.
module axi_burst_port #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned BURST_LEN = 256
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              rd_req,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] addr,
  output logic              done,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [3:0]        wr_strb,
  output logic              wr_pop,
  output logic              err,
  axi_burst_port_if.master  axi
);

  localparam int unsigned     CntW     = $clog2(BURST_LEN) + 1;
  localparam logic [CntW-1:0] LastBeat = CntW'(BURST_LEN - 1);
  localparam logic [CntW-1:0] NumBeats = CntW'(BURST_LEN);
  localparam logic [7:0]      AxLen    = 8'(BURST_LEN - 1);

  typedef enum logic [2:0] {StIdle, StRdAddr, StRdData, StWrXfer, StWrResp} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CntW-1:0]   beat_q, beat_d;
  logic              aw_done_q, aw_done_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      beat_q     <= '0;
      aw_done_q  <= 1'b0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      beat_q     <= beat_d;
      aw_done_q  <= aw_done_d;
      err_q      <= err_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    beat_d        = beat_q;
    aw_done_d     = aw_done_q;
    err_d         = err_q;
    done_d        = 1'b0;
    rd_valid_d    = 1'b0;
    rd_data_d     = rd_data_q;
    axi.m_arvalid = 1'b0;
    axi.m_rready  = 1'b0;
    axi.m_awvalid = 1'b0;
    axi.m_wvalid  = 1'b0;
    axi.m_wlast   = 1'b0;
    axi.m_bready  = 1'b0;
    wr_pop        = 1'b0;

    unique case (state_q)
      StIdle: begin
        // done_q gate: the requester is still dropping its level request this cycle
        if (!done_q && (rd_req || wr_req)) begin
          state_d   = rd_req ? StRdAddr : StWrXfer;
          addr_d    = {addr[ADDR_W-1:2], 2'b00};
          beat_d    = '0;
          aw_done_d = 1'b0;
        end
      end
      StRdAddr: begin
        axi.m_arvalid = 1'b1;
        if (axi.m_arready) state_d = StRdData;
      end
      StRdData: begin
        axi.m_rready = 1'b1;
        if (axi.m_rvalid) begin
          rd_data_d  = axi.m_rdata;
          rd_valid_d = 1'b1;
          done_d     = 1'b1;
          beat_d     = beat_q + CntW'(1);
          // Completion is by beat count; a misplaced rlast is only flagged.
          if ((axi.m_rlast != (beat_q == LastBeat)) || (axi.m_rresp != 2'b00)) err_d = 1'b1;
          if (beat_q == LastBeat) state_d = StIdle;
        end
      end
      StWrXfer: begin
        axi.m_awvalid = !aw_done_q;
        axi.m_wvalid  = (beat_q < NumBeats);
        axi.m_wlast   = axi.m_wvalid && (beat_q == LastBeat);
        wr_pop        = axi.m_wvalid && axi.m_wready;
        if (wr_pop) beat_d = beat_q + CntW'(1);
        if (axi.m_awvalid && axi.m_awready) aw_done_d = 1'b1;
        if (aw_done_d && (beat_d == NumBeats)) state_d = StWrResp;
      end
      StWrResp: begin
        axi.m_bready = 1'b1;
        if (axi.m_bvalid) begin
          done_d  = 1'b1;
          if (axi.m_bresp != 2'b00) err_d = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign axi.m_araddr  = addr_q;
  assign axi.m_awaddr  = addr_q;
  assign axi.m_arlen   = AxLen;
  assign axi.m_awlen   = AxLen;
  assign axi.m_wdata   = wr_data;
  assign axi.m_wstrb   = wr_strb;
  assign axi.m_axsize  = 3'b010;
  assign axi.m_axburst = 2'b01;

  assign done     = done_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign err      = err_q;

endmodule

// File: tb/tb_axi_burst_port.sv
// Directed bench for axi_burst_port: the bench plays requester, FIFOs and AXI slave.
module tb_axi_burst_port;
  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        rd_req = 1'b0;
  logic        wr_req = 1'b0;
  logic [31:0] addr = '0;
  logic        done;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic [31:0] wr_data = '0;
  logic [3:0]  wr_strb = '0;
  logic        wr_pop;
  logic        err;

  int checks = 0;
  int failures = 0;

  int          done_cnt, ar_cnt, aw_cnt, pop_cnt, wlast_cnt, wlast_pos;
  logic [31:0] ar_addr_seen, aw_addr_seen;
  logic [31:0] rd_q[$];

  axi_burst_port_if bus ();

  axi_burst_port dut (
    .clk      (clk),
    .nreset   (nreset),
    .rd_req   (rd_req),
    .wr_req   (wr_req),
    .addr     (addr),
    .done     (done),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .wr_data  (wr_data),
    .wr_strb  (wr_strb),
    .wr_pop   (wr_pop),
    .err      (err),
    .axi      (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Observed traffic, sampled on the falling edge.
  always @(negedge clk) begin
    if (rd_valid) rd_q.push_back(rd_data);
    if (done) done_cnt++;
    if (bus.m_arvalid && bus.m_arready) begin
      ar_cnt++;
      ar_addr_seen = bus.m_araddr;
    end
    if (bus.m_awvalid && bus.m_awready) begin
      aw_cnt++;
      aw_addr_seen = bus.m_awaddr;
    end
    if (wr_pop) begin
      if (bus.m_wlast) begin
        wlast_cnt++;
        wlast_pos = pop_cnt;
      end
      pop_cnt++;
    end
  end

  task automatic clear_mon();
    rd_q.delete();
    done_cnt = 0; ar_cnt = 0; aw_cnt = 0; pop_cnt = 0; wlast_cnt = 0; wlast_pos = -1;
    ar_addr_seen = '0; aw_addr_seen = '0;
  endtask

  task automatic idle_bus();
    bus.m_arready = 1'b0; bus.m_rvalid = 1'b0; bus.m_rdata = '0; bus.m_rresp = 2'b00;
    bus.m_rlast = 1'b0; bus.m_awready = 1'b0; bus.m_wready = 1'b0; bus.m_bvalid = 1'b0;
    bus.m_bresp = 2'b00;
  endtask

  task automatic do_reset();
    nreset = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
    idle_bus();
    repeat (2) tick();
    nreset = 1'b1;
    tick();
  endtask

  task automatic check_all_quiet(input string tag);
    check_eq({tag, "_arvalid"}, 64'(bus.m_arvalid), 64'(0));
    check_eq({tag, "_rready"}, 64'(bus.m_rready), 64'(0));
    check_eq({tag, "_awvalid"}, 64'(bus.m_awvalid), 64'(0));
    check_eq({tag, "_wvalid"}, 64'(bus.m_wvalid), 64'(0));
    check_eq({tag, "_bready"}, 64'(bus.m_bready), 64'(0));
    check_eq({tag, "_done"}, 64'(done), 64'(0));
    check_eq({tag, "_rd_valid"}, 64'(rd_valid), 64'(0));
    check_eq({tag, "_wr_pop"}, 64'(wr_pop), 64'(0));
  endtask

  // Slave side of one read burst; abort_beat >= 0 pulses nreset before that beat.
  task automatic do_read(input int ar_delay, input bit throttle, input logic [31:0] base,
                         input int err_beat, input int last_beat, input int abort_beat,
                         input logic [31:0] post_addr);
    int n;
    int i;
    bit hs;
    n = 0;
    while (!bus.m_arvalid && n < 50) begin tick(); n++; end
    check_eq("ar_valid_seen", 64'(bus.m_arvalid), 64'(1));
    check_eq("aw_idle_at_ar", 64'(bus.m_awvalid), 64'(0));
    rd_req = 1'b0;
    addr = post_addr;
    repeat (ar_delay) tick();
    check_eq("ar_hold", 64'(bus.m_arvalid), 64'(1));
    bus.m_arready = 1'b1;
    tick();
    bus.m_arready = 1'b0;
    i = 0;
    n = 0;
    while (i < 256 && n < 3000) begin
      if (i == abort_beat) begin
        #2 nreset = 1'b0;
        #1;
        check_all_quiet("abort");
        idle_bus();
        repeat (2) tick();
        nreset = 1'b1;
        tick();
        return;
      end
      bus.m_rvalid = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.m_rdata  = base + 32'(i);
      bus.m_rresp  = (i == err_beat) ? 2'b10 : 2'b00;
      bus.m_rlast  = (i == last_beat);
      hs = bus.m_rvalid && bus.m_rready;
      tick();
      n++;
      if (hs) i++;
    end
    bus.m_rvalid = 1'b0; bus.m_rlast = 1'b0; bus.m_rresp = 2'b00;
    check_eq("rd_beats", 64'(i), 64'(256));
  endtask

  task automatic verify_read(input logic [31:0] base);
    repeat (2) tick();
    check_eq("rd_count", 64'(rd_q.size()), 64'(256));
    check_eq("rd_done_count", 64'(done_cnt), 64'(256));
    for (int k = 0; k < rd_q.size(); k++) check_eq("rd_data", 64'(rd_q[k]), 64'(base + 32'(k)));
  endtask

  // Slave side of one write burst; wready toggles, AW accepted aw_late cycles after the
  // last W beat (aw_late=0: AW accepted immediately).
  task automatic do_write(input int aw_late, input logic [1:0] bresp);
    int n;
    int beats;
    bit hs, aw_hs, aw_taken;
    n = 0;
    while (!bus.m_awvalid && n < 50) begin tick(); n++; end
    check_eq("aw_valid_seen", 64'(bus.m_awvalid), 64'(1));
    wr_req = 1'b0;
    beats = 0;
    aw_taken = 1'b0;
    n = 0;
    while (beats < 256 && n < 3000) begin
      wr_data = 32'hC000_0000 | 32'(beats);
      wr_strb = 4'(beats);
      bus.m_wready  = (n % 2) == 1;
      bus.m_awready = (aw_late == 0) && !aw_taken;
      hs    = bus.m_wvalid && bus.m_wready;
      aw_hs = bus.m_awvalid && bus.m_awready;
      if (beats == 17 && hs) begin
        #1;
        check_eq("wdata_pass", 64'(bus.m_wdata), 64'h0000_0000_C000_0011);
        check_eq("wstrb_pass", 64'(bus.m_wstrb), 64'h1);
        check_eq("wr_pop_comb", 64'(wr_pop), 64'(1));
      end
      tick();
      n++;
      if (hs) beats++;
      if (aw_hs) aw_taken = 1'b1;
    end
    bus.m_wready = 1'b0;
    bus.m_awready = 1'b0;
    check_eq("wr_beats", 64'(beats), 64'(256));
    if (!aw_taken) begin
      repeat (aw_late) tick();
      check_eq("no_b_before_aw", 64'(bus.m_bready), 64'(0));
      check_eq("aw_hold", 64'(bus.m_awvalid), 64'(1));
      check_eq("w_stop", 64'(bus.m_wvalid), 64'(0));
      bus.m_awready = 1'b1;
      tick();
      bus.m_awready = 1'b0;
    end
    check_eq("bready", 64'(bus.m_bready), 64'(1));
    check_eq("no_early_done", 64'(done), 64'(0));
    bus.m_bvalid = 1'b1;
    bus.m_bresp = bresp;
    tick();
    bus.m_bvalid = 1'b0;
    bus.m_bresp = 2'b00;
    check_eq("done_after_b", 64'(done), 64'(1));
    tick();
    check_eq("done_single", 64'(done), 64'(0));
    check_eq("bready_drop", 64'(bus.m_bready), 64'(0));
  endtask

  initial begin
    idle_bus();
    clear_mon();
    repeat (2) tick();
    check_all_quiet("rst");
    check_eq("rst_err", 64'(err), 64'(0));
    nreset = 1'b1;
    tick();

    // 1: unaligned address, late arready, back-to-back beats
    clear_mon();
    rd_req = 1'b1; addr = 32'h1000_0003;
    do_read(2, 1'b0, 32'h0, -1, 255, -1, 32'h1000_0003);
    verify_read(32'h0);
    check_eq("t1_araddr", 64'(ar_addr_seen), 64'h1000_0000);
    check_eq("t1_ar_once", 64'(ar_cnt), 64'(1));
    check_eq("t1_arlen", 64'(bus.m_arlen), 64'(255));
    check_eq("t1_axsize", 64'(bus.m_axsize), 64'(2));
    check_eq("t1_axburst", 64'(bus.m_axburst), 64'(1));
    check_eq("t1_err", 64'(err), 64'(0));

    // 2: throttled rvalid
    clear_mon();
    rd_req = 1'b1; addr = 32'h3000_0000;
    do_read(0, 1'b1, 32'h5500_0000, -1, 255, -1, 32'h3000_0000);
    verify_read(32'h5500_0000);
    check_eq("t2_err", 64'(err), 64'(0));

    // 3: write, wready toggling, AW late
    clear_mon();
    wr_req = 1'b1; addr = 32'h2000_0400;
    do_write(5, 2'b00);
    check_eq("t3_pops", 64'(pop_cnt), 64'(256));
    check_eq("t3_wlast_cnt", 64'(wlast_cnt), 64'(1));
    check_eq("t3_wlast_pos", 64'(wlast_pos), 64'(255));
    check_eq("t3_aw_once", 64'(aw_cnt), 64'(1));
    check_eq("t3_awaddr", 64'(aw_addr_seen), 64'h2000_0400);
    check_eq("t3_awlen", 64'(bus.m_awlen), 64'(255));
    check_eq("t3_done", 64'(done_cnt), 64'(1));
    check_eq("t3_err", 64'(err), 64'(0));

    // 4: both requests together -> read first, then write at its own address
    clear_mon();
    rd_req = 1'b1; wr_req = 1'b1; addr = 32'h4000_0008;
    do_read(0, 1'b0, 32'h0, -1, 255, -1, 32'h4800_0010);
    verify_read(32'h0);
    check_eq("t4_araddr", 64'(ar_addr_seen), 64'h4000_0008);
    check_eq("t4_no_aw_yet", 64'(aw_cnt), 64'(0));
    clear_mon();
    do_write(0, 2'b00);
    check_eq("t4_awaddr", 64'(aw_addr_seen), 64'h4800_0010);
    check_eq("t4_pops", 64'(pop_cnt), 64'(256));
    check_eq("t4_no_ar", 64'(ar_cnt), 64'(0));

    // 5a: SLVERR on read beat 10
    do_reset();
    clear_mon();
    rd_req = 1'b1; addr = 32'h0;
    do_read(0, 1'b0, 32'h0, 10, 255, -1, 32'h0);
    verify_read(32'h0);
    check_eq("t5a_err", 64'(err), 64'(1));
    repeat (3) tick();
    check_eq("t5a_err_held", 64'(err), 64'(1));
    // 5b: rlast on beat 100 instead of 255
    do_reset();
    check_eq("t5b_err_cleared", 64'(err), 64'(0));
    clear_mon();
    rd_req = 1'b1;
    do_read(0, 1'b0, 32'h100, -1, 100, -1, 32'h0);
    verify_read(32'h100);
    check_eq("t5b_err", 64'(err), 64'(1));
    // 5c: SLVERR on B, then a clean read keeps err
    do_reset();
    clear_mon();
    wr_req = 1'b1;
    do_write(0, 2'b10);
    check_eq("t5c_err", 64'(err), 64'(1));
    clear_mon();
    rd_req = 1'b1;
    do_read(0, 1'b0, 32'h0, -1, 255, -1, 32'h0);
    verify_read(32'h0);
    check_eq("t5c_err_held", 64'(err), 64'(1));

    // 6: reset mid-read, then a fresh burst from beat 0
    do_reset();
    clear_mon();
    rd_req = 1'b1; addr = 32'h0;
    do_read(0, 1'b0, 32'h0, -1, 255, 50, 32'h0);
    check_all_quiet("t6_idle");
    clear_mon();
    rd_req = 1'b1; addr = 32'h6000_0000;
    do_read(1, 1'b0, 32'h7000_0000, -1, 255, -1, 32'h6000_0000);
    verify_read(32'h7000_0000);
    check_eq("t6_araddr", 64'(ar_addr_seen), 64'h6000_0000);
    check_eq("t6_err", 64'(err), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
